// File: rtl/dct_quant_packer.sv
// dct_quant_packer: quantizes 8-coefficient DCT blocks by a per-position rounding
// right shift, saturates to q_width and drains them through a ping-pong buffer.
module dct_quant_packer #(
  parameter int bit_width = 16,
  parameter int q_width   = 8
) (
  input  logic                        gated_clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic signed [bit_width-1:0] in_data,
  input  logic [23:0]                 qshift_cfg,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [q_width-1:0]   out_data,
  output logic [2:0]                  out_idx,
  output logic                        out_last,
  output logic                        overflow,
  output logic [7:0]                  sat_count
);

  localparam int q_max = 2 ** (q_width - 1) - 1;
  localparam int q_min = -(2 ** (q_width - 1));

  // Word address is {bank, position}.
  logic [q_width-1:0] mem [16];
  logic [1:0]         full;
  logic [2:0]         wr_idx;
  logic [2:0]         rd_idx;
  logic               wr_bank;
  logic               rd_bank;
  logic               drop;
  logic [23:0]        cfg_lat;

  logic [23:0]          cfg_eff;
  logic [2:0]           shift;
  logic signed [bit_width:0] ext;
  logic signed [bit_width:0] rnd;
  logic signed [bit_width:0] sum;
  logic signed [bit_width:0] q;
  logic [q_width-1:0]   q_sat;
  logic                 clamped;
  logic                 xfer;
  logic                 rd_free;
  logic                 tgt_busy;
  logic                 drop_now;
  logic                 wr_en;

  // Quantize the incoming coefficient and decide whether this sample is kept.
  always_comb begin
    // Position 0 uses the live config; the rest of the block uses the latched copy.
    cfg_eff = (wr_idx == 3'd0) ? qshift_cfg : cfg_lat;
    shift   = cfg_eff[3*wr_idx +: 3];
    ext     = {in_data[bit_width-1], in_data};
    rnd     = '0;
    if (shift != 3'd0) rnd = (bit_width + 1)'(1) << (shift - 3'd1);
    sum     = ext + rnd;
    q       = sum >>> shift;
    clamped = 1'b0;
    q_sat   = q[q_width-1:0];
    if (int'(q) > q_max) begin
      q_sat   = q_width'(q_max);
      clamped = 1'b1;
    end else if (int'(q) < q_min) begin
      q_sat   = q_width'(q_min);
      clamped = 1'b1;
    end
    xfer     = out_valid && out_ready;
    rd_free  = xfer && (rd_idx == 3'd7);
    // A bank being freed by the reader this cycle counts as available.
    tgt_busy = full[wr_bank] && !(rd_free && (rd_bank == wr_bank));
    drop_now = (wr_idx == 3'd0) ? tgt_busy : drop;
    wr_en    = in_valid && !drop_now;
  end

  assign out_valid = full[rd_bank];
  assign out_data  = mem[{rd_bank, rd_idx}];
  assign out_idx   = rd_idx;
  assign out_last  = out_valid && (rd_idx == 3'd7);

  // Write-side fill, drop tracking and read-side drain.
  always_ff @(posedge gated_clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      full      <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      drop      <= 1'b0;
      cfg_lat   <= '0;
      overflow  <= 1'b0;
      sat_count <= '0;
    end else begin
      if (in_valid) begin
        wr_idx <= wr_idx + 3'd1;
        if (wr_idx == 3'd0) begin
          cfg_lat <= qshift_cfg;
          drop    <= tgt_busy;
          if (tgt_busy) overflow <= 1'b1;
        end else if (wr_idx == 3'd7) begin
          drop <= 1'b0;
        end
        if (wr_en) begin
          mem[{wr_bank, wr_idx}] <= q_sat;
          if (clamped && (sat_count != 8'hff)) sat_count <= sat_count + 8'd1;
          if (wr_idx == 3'd7) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
          end
        end
      end
      // The writer never targets a full bank, so these full bits never collide.
      if (xfer) begin
        rd_idx <= rd_idx + 3'd1;
        if (rd_idx == 3'd7) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_quant_packer.sv
// Directed testbench for dct_quant_packer with hand-computed expected blocks.
module tb_dct_quant_packer;

  logic              gated_clk;
  logic              rst;
  logic              in_valid;
  logic signed [15:0] in_data;
  logic [23:0]       qshift_cfg;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_data;
  logic [2:0]        out_idx;
  logic              out_last;
  logic              overflow;
  logic [7:0]        sat_count;

  int n_checks = 0;
  int n_pass   = 0;
  int blk[8];
  int blk2[8];
  int blk3[8];

  dct_quant_packer #(
    .bit_width(16),
    .q_width  (8)
  ) dut (
    .gated_clk (gated_clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .qshift_cfg(qshift_cfg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .overflow  (overflow),
    .sat_count (sat_count)
  );

  initial gated_clk = 1'b0;
  always #5 gated_clk = ~gated_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge gated_clk);
    #1;
  endtask

  // Config is presented only at position 0; later positions see garbage config.
  task automatic send_block(input int v[8], input logic [23:0] cfg);
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      in_data    = 16'(v[i]);
      qshift_cfg = (i == 0) ? cfg : ~cfg;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic expect_block(input int v[8], input string tag);
    for (int i = 0; i < 8; i++) begin
      check({tag, "_valid"}, int'(out_valid), 1);
      check({tag, "_data"}, int'(out_data), v[i]);
      check({tag, "_idx"}, int'(out_idx), i);
      check({tag, "_last"}, int'(out_last), (i == 7) ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    qshift_cfg = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_idx", int'(out_idx), 0);
    check("rst_last", int'(out_last), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_sat", int'(sat_count), 0);

    // Pass-through, including latency of the first output.
    out_ready = 1'b1;
    blk = '{0, 1, -1, 5, -5, 100, -100, 127};
    for (int i = 0; i < 8; i++) begin
      in_valid   = 1'b1;
      in_data    = 16'(blk[i]);
      qshift_cfg = (i == 0) ? 24'h0 : 24'hffffff;
      tick();
      if (i == 6) check("pt_early_valid", int'(out_valid), 0);
    end
    in_valid = 1'b0;
    expect_block(blk, "pt");
    check("pt_done_valid", int'(out_valid), 0);
    check("pt_sat", int'(sat_count), 0);

    // Rounding shift of 2 at every position.
    blk  = '{5, 6, -5, -6, 7, -7, 2, -2};
    blk2 = '{1, 2, -1, -1, 2, -2, 1, 0};
    send_block(blk, 24'o22222222);
    expect_block(blk2, "rnd");

    // Saturation at q_width=8.
    blk  = '{300, -300, 128, -129, 127, -128, 0, 1000};
    blk2 = '{127, -128, 127, -128, 127, -128, 0, 127};
    send_block(blk, 24'h0);
    check("sat_count5", int'(sat_count), 5);
    expect_block(blk2, "sat");

    // Continuous clamped stream drained at full rate; the counter must stick at 255.
    blk = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    for (int b = 0; b < 32; b++) send_block(blk, 24'h0);
    check("sat_hold", int'(sat_count), 255);
    check("stream_no_overflow", int'(overflow), 0);
    for (int i = 0; i < 16; i++) tick();
    check("stream_drained", int'(out_valid), 0);

    // Backpressure: third block is dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      blk[i]  = 10 + i;
      blk2[i] = 20 + i;
      blk3[i] = 30 + i;
    end
    send_block(blk, 24'h0);
    send_block(blk2, 24'h0);
    send_block(blk3, 24'h0);
    check("drop_overflow", int'(overflow), 1);
    check("drop_valid", int'(out_valid), 1);
    tick();
    tick();
    check("hold_data", int'(out_data), 10);
    check("hold_idx", int'(out_idx), 0);
    out_ready = 1'b1;
    expect_block(blk, "blk1");
    expect_block(blk2, "blk2");
    check("drop_empty", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) blk3[i] = 40 + i;
    send_block(blk3, 24'h0);
    expect_block(blk3, "blk4");
    check("overflow_sticky", int'(overflow), 1);

    // Reset with one full bank and a partial block pending.
    out_ready = 1'b0;
    blk = '{80, 81, 82, 83, 84, 85, 86, 500};
    send_block(blk, 24'h0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(90 + i);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_valid", int'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    check("mid_rst_sat", int'(sat_count), 0);
    check("mid_rst_idx", int'(out_idx), 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) blk[i] = 100 + i;
    send_block(blk, 24'h0);
    expect_block(blk, "fresh");

    // Free-wins: last read of one bank coincides with position 0 of a new block.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      blk[i]  = 50 + i;
      blk2[i] = 60 + i;
      blk3[i] = 70 + i;
    end
    send_block(blk, 24'h0);
    send_block(blk2, 24'h0);
    check("fw_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("fw_idx7", int'(out_idx), 7);
    check("fw_last", int'(out_last), 1);
    check("fw_data7", int'(out_data), 57);
    in_valid   = 1'b1;
    in_data    = 16'(blk3[0]);
    qshift_cfg = 24'h0;
    tick();
    out_ready = 1'b0;
    for (int i = 1; i < 8; i++) begin
      in_data    = 16'(blk3[i]);
      qshift_cfg = 24'hffffff;
      tick();
    end
    in_valid = 1'b0;
    check("fw_overflow", int'(overflow), 0);
    out_ready = 1'b1;
    expect_block(blk2, "fw_b");
    expect_block(blk3, "fw_c");
    check("fw_empty", int'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dct_quant_packer.md
Name: dct_quant_packer

Overview:
Downstream stage of the DCT datapath. Consumes the signed DCT coefficient stream, one coefficient per gated_clk cycle with valid, in 8-coefficient blocks. Each coefficient is quantized by a per-position arithmetic right shift with rounding and saturated to q_width. Results are held in a two-bank ping-pong buffer and drained over a valid/ready handshake toward the entropy-coding side.

Parameters:
bit_width, 16, width of incoming DCT coefficients (signed)
q_width, 8, width of quantized output coefficients (signed); must be 2..bit_width

Ports:
gated_clk  input  1  gated clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_data holds a valid coefficient this cycle; no backpressure on the input side
in_data  input  bit_width  signed DCT coefficient
qshift_cfg  input  24  quantizer shifts: 3 bits per block position; bits [3k+2:3k] apply to position k
out_valid  output  1  out_data/out_idx/out_last are valid
out_ready  input  1  consumer accepts the current word
out_data  output  q_width  signed quantized coefficient
out_idx  output  3  position (0..7) of out_data within its block
out_last  output  1  high when out_idx==7 and out_valid is high
overflow  output  1  sticky; set when a block is dropped
sat_count  output  8  saturating count of saturated coefficients

Behaviour:
- Reset (rst=1 at a clock edge) applies to all state:
  - Outputs: out_valid=0, out_data=0, out_idx=0, out_last=0, overflow=0, sat_count=0.
  - Internal: both banks marked empty and cleared, wr_idx=0, wr_bank=0, rd_idx=0, rd_bank=0, drop flag=0.
  - Reset mid-block discards all partial and buffered data. The next in_valid after reset is position 0.
- Write side:
  - wr_idx counts accepted in_valid cycles 0..7 and wraps to 0. It advances on every in_valid, including dropped samples, so block alignment is preserved.
  - At position 0, qshift_cfg is latched. The latched value applies to all 8 positions of that block; mid-block changes are ignored.
  - Quantize with s = latched shift for position k:
    - If s=0, q = in_data.
    - Else q = (in_data + 2^(s-1)) >>> s, computed in bit_width+1 bits so the rounding add cannot wrap.
  - Saturate q to [-2^(q_width-1), 2^(q_width-1)-1]. Each clamped, non-dropped sample increments sat_count; sat_count holds at 255.
  - The quantized word is written into bank[wr_bank][wr_idx] on the same edge.
  - On acceptance of position 7, bank[wr_bank] is marked full and wr_bank toggles.
- Drop rule:
  - At position 0 acceptance, the target bank is checked. If bank[wr_bank] is full and not being freed this same cycle, the drop flag is set for the whole block.
  - The 8 samples of that block are then not written, do not mark the bank full, and do not toggle wr_bank. overflow is set and stays high until reset.
  - The drop flag clears at the wrap of wr_idx.
  - If the reader frees the target bank in the same cycle, the block is accepted (free-wins).
- Read side:
  - out_valid = bank[rd_bank] is full.
  - out_data = bank[rd_bank][rd_idx], out_idx = rd_idx.
  - A transfer occurs when out_valid && out_ready.
  - On a transfer, rd_idx increments. On transfer of position 7, bank[rd_bank] is marked empty, rd_bank toggles and rd_idx wraps to 0.
  - Outputs hold stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises on the edge that accepts input position 7. Position 0 of that block is therefore visible in the cycle after the 8th coefficient is accepted. With out_ready held at 1, a block drains in 8 cycles.
- Simultaneous events:
  - Writing to one bank while reading the other is always allowed.
  - A write-side full-set and a read-side full-clear on different banks in the same cycle both take effect.
  - Write and read never target the same bank word simultaneously, because a full bank is never written.
- in_valid gaps: wr_idx holds; a partial block waits indefinitely.

Test Plan:
- Pass-through: qshift_cfg=0, q_width=8, block in_data 0,1,-1,5,-5,100,-100,127 with out_ready=1 -> same 8 values on out_data, out_idx 0..7, out_last only at idx 7, out_valid first high the cycle after the 8th input, sat_count=0.
- Rounding/shift: qshift_cfg all positions s=2, inputs 5,6,-5,-6,7,-7,2,-2 -> outputs 1,2,-1,-1,2,-2,1,0.
- Saturation: s=0, inputs 300,-300,128,-129,127,-128,0,1000 -> outputs 127,-128,127,-128,127,-128,0,127; sat_count=5. Then feed 255 further clamped samples -> sat_count holds at 255.
- Backpressure/drop: out_ready=0, stream 3 consecutive blocks (values 10.., 20.., 30..) -> blocks 1 and 2 buffered, block 3 dropped, overflow=1. With out_ready=1, blocks 1 then 2 drain intact; a 4th block is accepted normally.
- Free-wins: with both banks full, assert out_ready so the position-7 read of bank 0 coincides with position 0 of a new block -> new block accepted into bank 0, overflow stays 0.
- Reset mid-operation: rst=1 for one cycle after 4 samples of a block and with one full bank pending -> out_valid=0 next cycle, overflow=0, sat_count=0. The next 8 inputs form a fresh block at idx 0..7.
